// File: rtl/store_demux3.sv
// rtl/store_demux3.sv - one-to-three write-stream demux with per-channel FIFOs
module store_demux3 #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [2:0]       out_valid,
    input  logic [2:0]       out_ready,
    output logic [WIDTH-1:0] out_data_a,
    output logic [WIDTH-1:0] out_data_b,
    output logic [WIDTH-1:0] out_data_c,
    output logic             bad_sel,
    output logic [7:0]       bad_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [2:0]       w_full;
    logic [WIDTH-1:0] w_head [3];
    logic             w_accept;
    logic             r_bad_sel;
    logic [7:0]       r_bad_cnt;

    assign w_accept = in_valid && in_ready;

    // Ready depends only on the selected FIFO's fullness; code 11 is always taken and dropped
    always_comb begin
        in_ready = 1'b1;
        case (in_sel)
            2'b00:   in_ready = !w_full[0];
            2'b01:   in_ready = !w_full[1];
            2'b10:   in_ready = !w_full[2];
            default: in_ready = 1'b1;
        endcase
    end

    for (genvar k = 0; k < 3; k++) begin : g_ch
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [AW-1:0]    r_wptr;
        logic [AW-1:0]    r_rptr;
        logic [AW:0]      r_cnt;
        logic             w_push;
        logic             w_pop;

        // A pop needs a stored word, so an empty FIFO never pops even if a push lands this cycle
        assign w_push       = w_accept && (in_sel == 2'(k));
        assign w_pop        = (r_cnt != '0) && out_ready[k];
        assign w_full[k]    = (r_cnt == FULL_CNT);
        assign out_valid[k] = (r_cnt != '0);
        assign w_head[k]    = r_mem[r_rptr];

        // Channel FIFO storage, pointers and occupancy; reset also clears storage so heads read 0
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_mem[i] <= '0;
                end
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
            end else begin
                if (w_push) begin
                    r_mem[r_wptr] <= in_data;
                    r_wptr        <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + 1'b1;
                    2'b01:   r_cnt <= r_cnt - 1'b1;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    assign out_data_a = w_head[0];
    assign out_data_b = w_head[1];
    assign out_data_c = w_head[2];

    // Sticky flag and saturating counter for words dropped on the invalid select code
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bad_sel <= 1'b0;
            r_bad_cnt <= 8'd0;
        end else if (w_accept && (in_sel == 2'b11)) begin
            r_bad_sel <= 1'b1;
            if (r_bad_cnt != 8'hFF) begin
                r_bad_cnt <= r_bad_cnt + 8'd1;
            end
        end
    end

    assign bad_sel = r_bad_sel;
    assign bad_cnt = r_bad_cnt;

endmodule

// File: tb/tb_store_demux3.sv
// tb/tb_store_demux3.sv - self-checking bench for store_demux3
module tb_store_demux3;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_sel;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       out_valid;
    logic [2:0]       out_ready;
    logic [WIDTH-1:0] out_data_a;
    logic [WIDTH-1:0] out_data_b;
    logic [WIDTH-1:0] out_data_c;
    logic             bad_sel;
    logic [7:0]       bad_cnt;

    int n_chk = 0;
    int n_err = 0;

    store_demux3 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data_a(out_data_a), .out_data_b(out_data_b), .out_data_c(out_data_c),
        .bad_sel(bad_sel), .bad_cnt(bad_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [31:0] d;
        logic [2:0]  ordy;
        logic        e_rdy;
        logic [2:0]  e_ov;
        int          e_ch;
        logic [31:0] e_dat;
    } vec_t;

    vec_t tbl [14];

    logic [31:0] qa [$];
    logic [31:0] qb [$];
    logic [31:0] qc [$];
    int          m_bad;
    logic        m_bad_sel;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [1:0] sel, input logic [31:0] d,
                                input logic [2:0] ordy, input logic e_rdy, input logic [2:0] e_ov,
                                input int e_ch, input logic [31:0] e_dat);
        vec_t r;
        r.v = v; r.sel = sel; r.d = d; r.ordy = ordy;
        r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_ch = e_ch; r.e_dat = e_dat;
        return r;
    endfunction

    function automatic logic [31:0] dut_head(input int k);
        case (k)
            0:       return out_data_a;
            1:       return out_data_b;
            default: return out_data_c;
        endcase
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return qa.size();
            1:       return qb.size();
            default: return qc.size();
        endcase
    endfunction

    function automatic logic [31:0] qhead(input int k);
        case (k)
            0:       return qa[0];
            1:       return qb[0];
            default: return qc[0];
        endcase
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_sel = 2'b00; in_data = '0; out_ready = 3'b000;
        @(posedge clk); #1;
        rst = 1'b0;
        qa.delete(); qb.delete(); qc.delete();
        m_bad = 0; m_bad_sel = 1'b0;
    endtask

    initial begin
        logic        all_rdy;
        logic        stalled;
        logic        exp_rdy;
        logic [2:0]  exp_ov;

        tbl[0]  = mk(1, 2'd0, 32'h11111111, 3'b111, 1, 3'b001, 0, 32'h11111111);
        tbl[1]  = mk(1, 2'd1, 32'h22222222, 3'b111, 1, 3'b010, 1, 32'h22222222);
        tbl[2]  = mk(1, 2'd2, 32'h33333333, 3'b111, 1, 3'b100, 2, 32'h33333333);
        tbl[3]  = mk(0, 2'd0, 32'h0,        3'b111, 1, 3'b000, 3, 32'h0);
        tbl[4]  = mk(1, 2'd1, 32'hB0,       3'b101, 1, 3'b010, 1, 32'hB0);
        tbl[5]  = mk(1, 2'd0, 32'hA0,       3'b101, 1, 3'b011, 0, 32'hA0);
        tbl[6]  = mk(1, 2'd1, 32'hB1,       3'b101, 1, 3'b010, 1, 32'hB0);
        tbl[7]  = mk(1, 2'd1, 32'hB2,       3'b101, 0, 3'b010, 1, 32'hB0);
        tbl[8]  = mk(1, 2'd1, 32'hB2,       3'b111, 0, 3'b010, 1, 32'hB1);
        tbl[9]  = mk(1, 2'd1, 32'hB2,       3'b111, 1, 3'b010, 1, 32'hB2);
        tbl[10] = mk(0, 2'd0, 32'h0,        3'b111, 1, 3'b000, 3, 32'h0);
        tbl[11] = mk(1, 2'd3, 32'hDEAD0001, 3'b111, 1, 3'b000, 3, 32'h0);
        tbl[12] = mk(1, 2'd3, 32'hDEAD0002, 3'b111, 1, 3'b000, 3, 32'h0);
        tbl[13] = mk(1, 2'd3, 32'hDEAD0003, 3'b111, 1, 3'b000, 3, 32'h0);

        apply_reset();

        // Reset then idle
        for (int c = 0; c < 5; c++) begin
            chk("rst_out_valid", 32'(out_valid), 32'h0);
            chk("rst_data_a", out_data_a, 32'h0);
            chk("rst_data_b", out_data_b, 32'h0);
            chk("rst_data_c", out_data_c, 32'h0);
            chk("rst_in_ready", 32'(in_ready), 32'h1);
            chk("rst_bad_cnt", 32'(bad_cnt), 32'h0);
            chk("rst_bad_sel", 32'(bad_sel), 32'h0);
            @(posedge clk); #1;
        end

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            in_valid = tbl[i].v; in_sel = tbl[i].sel; in_data = tbl[i].d; out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].e_ch < 3) begin
                chk($sformatf("tbl%0d_data", i), dut_head(tbl[i].e_ch), tbl[i].e_dat);
            end
        end
        in_valid = 1'b0;
        #1;
        chk("bad_sel_after3", 32'(bad_sel), 32'h1);
        chk("bad_cnt_after3", 32'(bad_cnt), 32'd3);

        // Saturation of the drop counter
        all_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1; in_sel = 2'b11; in_data = 32'(i);
            #1;
            if (in_ready !== 1'b1) all_rdy = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bad_in_ready_all", 32'(all_rdy), 32'h1);
        chk("bad_cnt_sat", 32'(bad_cnt), 32'd255);
        chk("bad_no_valid", 32'(out_valid), 32'h0);

        // Mid-stream reset with words buffered in A
        out_ready = 3'b000;
        in_valid = 1'b1; in_sel = 2'b00; in_data = 32'h01;
        @(posedge clk); #1;
        in_data = 32'h02;
        @(posedge clk); #1;
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        rst = 1'b1; in_data = 32'h03;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_data_a", out_data_a, 32'h0);
        chk("mid_rst_bad_cnt", 32'(bad_cnt), 32'h0);
        chk("mid_rst_bad_sel", 32'(bad_sel), 32'h0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'h1);
        in_valid = 1'b1; in_sel = 2'b00; in_data = 32'hCAFEF00D; out_ready = 3'b001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("post_rst_valid", 32'(out_valid), 32'h1);
        chk("post_rst_data_a", out_data_a, 32'hCAFEF00D);
        @(posedge clk); #1;
        chk("post_rst_drain", 32'(out_valid), 32'h0);

        // Randomized traffic against a queue-based model
        apply_reset();
        stalled = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!stalled) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = 2'($urandom_range(0, 3));
                in_data  = $urandom;
            end
            out_ready = 3'($urandom);
            #1;
            exp_rdy = (in_sel == 2'b11) ? 1'b1 : (qsize(int'(in_sel)) < DEPTH);
            chk("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
            for (int k = 0; k < 3; k++) begin
                exp_ov[k] = (qsize(k) > 0);
            end
            chk("rnd_out_valid", 32'(out_valid), 32'(exp_ov));
            for (int k = 0; k < 3; k++) begin
                if (qsize(k) > 0) chk($sformatf("rnd_head%0d", k), dut_head(k), qhead(k));
            end
            chk("rnd_bad_cnt", 32'(bad_cnt), 32'(m_bad));
            chk("rnd_bad_sel", 32'(bad_sel), 32'(m_bad_sel));
            @(posedge clk);
            if (qa.size() > 0 && out_ready[0]) void'(qa.pop_front());
            if (qb.size() > 0 && out_ready[1]) void'(qb.pop_front());
            if (qc.size() > 0 && out_ready[2]) void'(qc.pop_front());
            if (in_valid && exp_rdy) begin
                case (in_sel)
                    2'b00: qa.push_back(in_data);
                    2'b01: qb.push_back(in_data);
                    2'b10: qc.push_back(in_data);
                    default: begin
                        m_bad_sel = 1'b1;
                        if (m_bad < 255) m_bad++;
                    end
                endcase
            end
            stalled = in_valid && !exp_rdy;
            #1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/store_demux3.md
# store_demux3

Routes a single 32-bit write stream to one of three destination channels, each with its own small FIFO and valid/ready handshake. It is the distribution end of the three-way source-select path used in the datapath: one producer (CPU store/write-back port) feeds three consumers (e.g. display, score, and sound registers). Per-channel buffering lets a stalled consumer block only its own traffic. Invalid select codes are dropped and counted.

## Interface

- WIDTH, 32, data width of every channel
- DEPTH, 2, entries per channel FIFO (power of two, >= 2)
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts the word this cycle
- in_sel  input  2  destination: 00 = A, 01 = B, 10 = C, 11 = invalid
- in_data  input  WIDTH  word to route
- out_valid  output  3  bit0 = A, bit1 = B, bit2 = C; channel FIFO non-empty
- out_ready  input  3  per-channel consumer ready, same bit order
- out_data_a / out_data_b / out_data_c  output  WIDTH  head word of each channel FIFO
- bad_sel  output  1  sticky flag: an in_sel = 11 word was accepted
- bad_cnt  output  8  saturating count of dropped in_sel = 11 words

## Operation

- Push: in_valid && in_ready. The word is written into the FIFO chosen by in_sel.
- in_ready is combinational from in_sel and FIFO state:
  - !full of the selected FIFO for 00/01/10
  - constant 1 for 11
- in_ready never depends on out_ready. A full FIFO refuses the push even if it pops in the same cycle.
- The producer holds in_sel/in_data stable while in_valid && !in_ready.
- in_sel = 11 accepted:
  - word discarded; no FIFO changes
  - bad_sel <= 1
  - bad_cnt <= bad_cnt + 1, saturating at 255
- Pop on channel k: out_valid[k] && out_ready[k]. The read pointer advances.
- out_data_k always shows the current head entry and is stable while out_valid[k] && !out_ready[k].
- Each FIFO keeps read/write pointers plus a count (0..DEPTH). full = (count == DEPTH); empty = (count == 0).
- Pointer arithmetic: log2(DEPTH) bits, wrapping naturally from DEPTH-1 to 0.
- Simultaneous push and pop on the same non-full, non-empty FIFO: both occur and count is unchanged.
- Simultaneous push and pop on an empty FIFO: no pop occurs (out_valid = 0), the push occurs, count becomes 1.
- Channels are independent. A pop on one channel never affects another.
- Order within a channel is strictly FIFO. No ordering is defined across channels.
- A consumer with out_ready held high drains one word per cycle.

## Timing

- Reset (rst high at an edge), applied regardless of in-flight traffic:
  - all FIFO counts and pointers cleared; buffered words lost
  - out_valid = 000; out_data_a/b/c = 0 (storage cleared)
  - bad_sel = 0, bad_cnt = 0
  - in_ready follows the post-reset state: 1
- While rst is high, pushes and pops are ignored.
- Push-to-output latency is 1 cycle. A word pushed at edge N sets out_valid[k] after edge N, with data on out_data_k in cycle N+1.
- Pop takes effect at the edge. The next head, or out_valid = 0, is visible the following cycle.
- Sustained throughput is one push per cycle when the selected consumer keeps out_ready high.
- bad_sel/bad_cnt update at the accepting edge and are visible the next cycle.

## Test plan

- Reset then idle: out_valid = 000, out_data_* = 0, in_ready = 1, bad_cnt = 0 for 5 cycles.
- Push 0x11111111 to A, 0x22222222 to B, 0x33333333 to C on consecutive cycles, all out_ready = 1. Required: each word appears exactly one cycle after its push, and each out_valid bit pulses for 1 cycle.
- Channel B backpressure (out_ready[1] = 0), push 0xB0, 0xB1, 0xB2 to B:
  - first two accepted; third sees in_ready = 0 and is held
  - raising out_ready[1] delivers 0xB0, 0xB1, 0xB2 in order
  - pushes to A continue unblocked throughout
- Full FIFO with a simultaneous pop on that channel: push refused that cycle, accepted the next cycle, and no data is lost or duplicated.
- Three pushes with in_sel = 11: in_ready = 1 every cycle, no out_valid activity, bad_sel = 1, bad_cnt = 3. After 300 such pushes bad_cnt holds at 255.
- Fill A with 2 words, assert rst for 1 cycle mid-stream: out_valid = 000 and bad_cnt = 0 the next cycle. A new push to A then appears unchanged 1 cycle later.
